// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_if,
  output logic              stall_d,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, SERV_IF, SERV_D} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_if;
  logic             grant_d;

  always_comb begin
    starved  = (starve_cnt == CNT_W'(STARVE_MAX));
    grant_if = if_req & (~d_req | starved);
    grant_d  = d_req & ~grant_if;
  end

  assign stall_if = if_req & ~if_done;
  assign stall_d  = d_req & ~d_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= 3'b000;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state      <= SERV_IF;
            starve_cnt <= '0;
            mem_valid  <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_funct3 <= 3'b010;
          end else if (grant_d) begin
            state      <= SERV_D;
            mem_valid  <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_funct3 <= d_funct3;
            // Only data wins that actually bypass a waiting fetch count toward starvation.
            if (if_req && !starved) starve_cnt <= starve_cnt + 1'b1;
          end
        end
        SERV_IF: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            if_done   <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end
        SERV_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            d_done    <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: stimulus pushes expected commands/read data, a negedge monitor pops and compares.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0]  if_addr = '0, d_addr = '0, mem_addr;
  logic [31:0] d_wdata = '0, if_rdata, d_rdata, mem_wdata, mem_rdata = '0;
  logic [2:0]  d_funct3 = '0, mem_funct3;
  logic        if_done, d_done, stall_if, stall_d, mem_valid, mem_we;
  logic        mem_ready = 1'b0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_rdata(d_rdata), .d_done(d_done), .stall_if(stall_if),
    .stall_d(stall_d), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          wait_cyc = 0;
  int          mcnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model: ready after wait_cyc extra cycles of mem_valid.
  always @(posedge clk) begin
    #1;
    if (mem_valid) begin
      mem_ready = (mcnt == wait_cyc);
      mem_rdata = mem_ready ? mem[mem_addr] : 32'h0;
      mcnt++;
    end else begin
      mem_ready = 1'b0;
      mcnt = 0;
    end
  end

  // Monitor / scoreboard
  logic prev_valid = 1'b0;
  cmd_t held, cur, expc;
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      cur = '{mem_we, mem_addr, mem_wdata, mem_funct3};
      if (mem_valid && !prev_valid) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got cmd %h expected none", cur);
        end else begin
          expc = cmd_q.pop_front();
          check("grant_cmd", 64'(cur), 64'(expc));
        end
        held = cur;
      end else if (mem_valid) begin
        check("cmd_stable", 64'(cur), 64'(held));
      end
      if (if_done) begin
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_if_done: got 1 expected 0");
        end else check("if_rdata", 64'(if_rdata), 64'(if_q.pop_front()));
      end
      if (d_done) begin
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_d_done: got 1 expected 0");
        end else check("d_rdata", 64'(d_rdata), 64'(d_q.pop_front()));
      end
      check("one_done", 64'(if_done & d_done), 64'(0));
      check("stall_if", 64'(stall_if), 64'(if_req & ~if_done));
      check("stall_d", 64'(stall_d), 64'(d_req & ~d_done));
      prev_valid = mem_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_for(input bit want_if, input int lim, output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < lim; i++) begin
      tick(); n++;
      if (want_if ? if_done : d_done) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout_%s: got no done expected done", want_if ? "if" : "d");
    end
  endtask

  task automatic set_d(input logic we, input logic [7:0] a, input logic [31:0] wd, input logic [2:0] f3);
    d_we = we; d_addr = a; d_wdata = wd; d_funct3 = f3; d_req = 1'b1;
  endtask

  initial begin
    int n, nd;
    logic [31:0] last_load;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h00500093;
    mem[8'h14] = 32'h0badf00d;
    mem[8'h18] = 32'h00000013;
    mem[8'h40] = 32'h11223344;
    mem[8'h44] = 32'hcafe0001;
    mem[8'h50] = 32'h5a5a5a5a;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_valid", 64'(mem_valid), 64'(0));
    check("rst_outs", 64'({mem_we, mem_addr, mem_funct3, if_done, d_done}), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: lone fetch, memory ready after 2 extra cycles
    wait_cyc = 2;
    if_addr = 8'h10; if_req = 1'b1;
    cmd_q.push_back('{1'b0, 8'h10, 32'h0, 3'b010});
    if_q.push_back(32'h00500093);
    check("pre_grant_valid", 64'(mem_valid), 64'(0));
    tick();
    check("grant_latency", 64'(mem_valid), 64'(1));
    wait_for(1'b1, 20, n);
    if_req = 1'b0;
    check("fetch_wait_ticks", 64'(n), 64'(3));
    tick();

    // 2: simultaneous, data first, fetch after one idle cycle
    wait_cyc = 0;
    if_addr = 8'h14; if_req = 1'b1;
    set_d(1'b0, 8'h40, 32'h0, 3'b010);
    cmd_q.push_back('{1'b0, 8'h40, 32'h0, 3'b010});
    cmd_q.push_back('{1'b0, 8'h14, 32'h0, 3'b010});
    d_q.push_back(32'h11223344);
    if_q.push_back(32'h0badf00d);
    wait_for(1'b0, 20, n);
    d_req = 1'b0;
    check("data_first_ticks", 64'(n), 64'(2));
    wait_for(1'b1, 20, n);
    if_req = 1'b0;
    check("fetch_after_idle", 64'(n), 64'(2));
    tick();

    // 3: starvation guard, 4 data grants then a forced fetch
    if_addr = 8'h18; if_req = 1'b1;
    set_d(1'b0, 8'h44, 32'h0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      cmd_q.push_back('{1'b0, 8'h44, 32'h0, 3'b010});
      d_q.push_back(32'hcafe0001);
    end
    cmd_q.push_back('{1'b0, 8'h18, 32'h0, 3'b010});
    if_q.push_back(32'h00000013);
    last_load = 32'hcafe0001;
    nd = 0; n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (d_done) nd++;
      if (if_done) begin n = 1; break; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve_fetch_seen", 64'(n), 64'(1));
    check("starve_data_grants", 64'(nd), 64'(4));
    check("starve_cnt_clear", 64'(dut.starve_cnt), 64'(0));
    tick();

    // 4: store with a 5-cycle memory stall
    wait_cyc = 5;
    set_d(1'b1, 8'h20, 32'hDEADBEEF, 3'b000);
    cmd_q.push_back('{1'b1, 8'h20, 32'hDEADBEEF, 3'b000});
    d_q.push_back(last_load);
    wait_for(1'b0, 30, n);
    d_req = 1'b0;
    check("store_ticks", 64'(n), 64'(7));
    tick();

    // 5: request dropped mid-service still completes
    wait_cyc = 3;
    set_d(1'b0, 8'h50, 32'h0, 3'b010);
    cmd_q.push_back('{1'b0, 8'h50, 32'h0, 3'b010});
    d_q.push_back(32'h5a5a5a5a);
    tick(); tick();
    d_req = 1'b0;
    wait_for(1'b0, 20, n);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_regrant", 64'(mem_valid), 64'(0));
    end

    // 6a: reset during a data access with fetch pending clears starve_cnt
    wait_cyc = 10;
    if_addr = 8'h18; if_req = 1'b1;
    set_d(1'b0, 8'h40, 32'h0, 3'b010);
    cmd_q.push_back('{1'b0, 8'h40, 32'h0, 3'b010});
    tick(); tick();
    check("starve_cnt_one", 64'(dut.starve_cnt), 64'(1));
    @(negedge clk); #2;
    rst = 1'b0; #1;
    check("rst_d_valid", 64'(mem_valid), 64'(0));
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("rst_starve_cnt", 64'(dut.starve_cnt), 64'(0));
    tick();

    // 6b: reset mid-fetch, no if_done, then clean lone fetch
    if_addr = 8'h10; if_req = 1'b1;
    cmd_q.push_back('{1'b0, 8'h10, 32'h0, 3'b010});
    tick(); tick(); tick();
    @(negedge clk); #2;
    rst = 1'b0; #1;
    check("rst_if_valid", 64'(mem_valid), 64'(0));
    check("rst_if_done", 64'(if_done), 64'(0));
    if_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) tick();
    wait_cyc = 0;
    if_addr = 8'h14; if_req = 1'b1;
    cmd_q.push_back('{1'b0, 8'h14, 32'h0, 3'b010});
    if_q.push_back(32'h0badf00d);
    tick();
    check("post_rst_latency", 64'(mem_valid), 64'(1));
    wait_for(1'b1, 20, n);
    if_req = 1'b0;
    check("post_rst_ticks", 64'(n), 64'(1));
    repeat (3) tick();

    check("cmd_q_empty", 64'(cmd_q.size()), 64'(0));
    check("if_q_empty", 64'(if_q.size()), 64'(0));
    check("d_q_empty", 64'(d_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
